// File: rtl/fft_pkg.sv
// fft_pkg: shared types and index helpers for the radix-2 DIT FFT sequencer.
// Helpers work on a fixed 16-bit container; callers size-cast to their own width.
package fft_pkg;

  localparam int FFT_MAX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } fft_state_e;

  // Reverse the low 'width' bits of idx; bits at and above 'width' come back as zero.
  function automatic logic [FFT_MAX_W-1:0] bitrev(input logic [FFT_MAX_W-1:0] idx,
                                                   input int                   width);
    logic [FFT_MAX_W-1:0] r;
    r = '0;
    for (int b = 0; b < FFT_MAX_W; b++) begin
      if (b < width) begin
        r = r | (((idx >> (width - 1 - b)) & 16'd1) << b);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Open a zero bit at position pos: bits below pos stay put, bits at/above pos move up by one.
  function automatic logic [FFT_MAX_W-1:0] insert_zero(input logic [FFT_MAX_W-1:0] i,
                                                        input int                   pos);
    logic [FFT_MAX_W-1:0] low_mask;
    low_mask = (16'd1 << pos) - 16'd1;
    return ((i & ~low_mask) << 1) | (i & low_mask);
  endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// fft_wb_delay: LAT-deep shift register that replays the read-address pair as the
// write-back pair once the butterfly pipeline has produced its results.
module fft_wb_delay
#(
  parameter int LAT = 2,
  parameter int AW  = 5
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_en,
  input  logic [AW-1:0] i_adr_a,
  input  logic [AW-1:0] i_adr_b,
  output logic          o_en,
  output logic [AW-1:0] o_adr_a,
  output logic [AW-1:0] o_adr_b
);
  import fft_pkg::*;

  logic [LAT-1:0] r_en;
  logic [AW-1:0]  r_adr_a [LAT];
  logic [AW-1:0]  r_adr_b [LAT];

  // Shift the {en, a, b} triple one stage per clock; reset empties every stage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_en <= '0;
      for (int k = 0; k < LAT; k++) begin
        r_adr_a[k] <= '0;
        r_adr_b[k] <= '0;
      end
    end else begin
      r_en[0]    <= i_en;
      r_adr_a[0] <= i_adr_a;
      r_adr_b[0] <= i_adr_b;
      for (int k = 1; k < LAT; k++) begin
        r_en[k]    <= r_en[k-1];
        r_adr_a[k] <= r_adr_a[k-1];
        r_adr_b[k] <= r_adr_b[k-1];
      end
    end
  end

  assign o_en    = r_en[LAT-1];
  assign o_adr_a = r_adr_a[LAT-1];
  assign o_adr_b = r_adr_b[LAT-1];

endmodule

// File: rtl/fft_ctrl.sv
// fft_ctrl: sequencer for an in-place radix-2 DIT FFT over N = 2**N_LOG2 points.
// Walks one butterfly per cycle through every stage, issuing read pairs and twiddle
// indices, and replays each pair as a write-back pair BFLY_LAT cycles later.
// Each stage ends with a BFLY_LAT-cycle drain so a stage never reads a location
// whose previous-stage result is still in flight.
// Optional feature macro: FFT_BITREV_LOAD_EN adds a LOAD state that streams N input
// samples into the RAM at bit-reversed addresses before computing.
module fft_ctrl
#(
  parameter int N_LOG2   = 5,
  parameter int BFLY_LAT = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
`ifdef FFT_BITREV_LOAD_EN
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        load_sel,
`endif
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(N_LOG2)-1:0]   stage,
  output logic                        rd_en,
  output logic [N_LOG2-1:0]           rd_adr_a,
  output logic [N_LOG2-1:0]           rd_adr_b,
  output logic [N_LOG2-2:0]           tw_adr,
  output logic                        wr_en,
  output logic [N_LOG2-1:0]           wr_adr_a,
  output logic [N_LOG2-1:0]           wr_adr_b
);
  import fft_pkg::*;

  localparam int N      = 2 ** N_LOG2;
  localparam int HALF   = N / 2;
  localparam int PERIOD = HALF + BFLY_LAT;
  localparam int CNT_W  = $clog2(PERIOD);
  localparam int SW     = $clog2(N_LOG2);
  localparam int TW_W   = N_LOG2 - 1;

  fft_state_e        r_state;
  fft_state_e        w_state_nx;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic [SW-1:0]     r_stage;
  logic [SW-1:0]     w_stage_nx;
  logic              w_rd_en;
  logic              w_done;
  logic [N_LOG2-2:0] w_bfly;
  logic [N_LOG2-1:0] w_rd_a;
  logic [N_LOG2-1:0] w_rd_b;
  logic [TW_W-1:0]   w_tw;
  logic              w_dly_en;
  logic [N_LOG2-1:0] w_dly_a;
  logic [N_LOG2-1:0] w_dly_b;
`ifdef FFT_BITREV_LOAD_EN
  logic [N_LOG2-1:0] r_ld_cnt;
  logic [N_LOG2-1:0] w_ld_cnt_nx;
  logic              w_load_wr;
  logic              w_in_ready;
  logic              w_load_sel;
`endif

  // State, butterfly/drain counter, stage index and load counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_stage  <= '0;
`ifdef FFT_BITREV_LOAD_EN
      r_ld_cnt <= '0;
`endif
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_stage  <= w_stage_nx;
`ifdef FFT_BITREV_LOAD_EN
      r_ld_cnt <= w_ld_cnt_nx;
`endif
    end
  end

  // Next-state and control decode: r_cnt runs 0..PERIOD-1 per stage, reading while below HALF.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_stage_nx  = r_stage;
    w_rd_en     = 1'b0;
    w_done      = 1'b0;
`ifdef FFT_BITREV_LOAD_EN
    w_ld_cnt_nx = r_ld_cnt;
    w_load_wr   = 1'b0;
    w_in_ready  = 1'b0;
    w_load_sel  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
`ifdef FFT_BITREV_LOAD_EN
          w_state_nx  = ST_LOAD;
          w_ld_cnt_nx = '0;
`else
          w_state_nx  = ST_COMPUTE;
`endif
          w_cnt_nx    = '0;
          w_stage_nx  = '0;
        end else begin
          w_state_nx  = ST_IDLE;
        end
      end
`ifdef FFT_BITREV_LOAD_EN
      ST_LOAD: begin
        w_in_ready = 1'b1;
        w_load_sel = 1'b1;
        if (in_valid) begin
          w_load_wr = 1'b1;
          if (r_ld_cnt == N_LOG2'(N - 1)) begin
            w_ld_cnt_nx = '0;
            w_state_nx  = ST_COMPUTE;
          end else begin
            w_ld_cnt_nx = r_ld_cnt + N_LOG2'(1);
          end
        end else begin
          w_ld_cnt_nx = r_ld_cnt;
        end
      end
`endif
      ST_COMPUTE: begin
        w_rd_en = (r_cnt < CNT_W'(HALF));
        if (r_cnt == CNT_W'(PERIOD - 1)) begin
          w_cnt_nx = '0;
          if (r_stage == SW'(N_LOG2 - 1)) begin
            w_state_nx = ST_DONE;
          end else begin
            w_stage_nx = r_stage + SW'(1);
          end
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_done     = 1'b1;
        w_stage_nx = '0;
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
        w_stage_nx = '0;
      end
    endcase
  end

  // Butterfly address generation; all address outputs stay at zero while no read is issued.
  always_comb begin
    w_bfly = r_cnt[N_LOG2-2:0];
    w_rd_a = '0;
    w_rd_b = '0;
    w_tw   = '0;
    if (w_rd_en) begin
      w_rd_a = N_LOG2'(insert_zero(FFT_MAX_W'(w_bfly), int'(r_stage)));
      w_rd_b = w_rd_a | N_LOG2'(16'd1 << r_stage);
      w_tw   = TW_W'((FFT_MAX_W'(w_bfly) & ((16'd1 << r_stage) - 16'd1))
                     << (TW_W - int'(r_stage)));
    end else begin
      w_rd_a = '0;
      w_rd_b = '0;
      w_tw   = '0;
    end
  end

  fft_wb_delay #(
    .LAT (BFLY_LAT),
    .AW  (N_LOG2)
  ) u_wb_delay (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_rd_en),
    .i_adr_a (w_rd_a),
    .i_adr_b (w_rd_b),
    .o_en    (w_dly_en),
    .o_adr_a (w_dly_a),
    .o_adr_b (w_dly_b)
  );

  assign busy     = (r_state != ST_IDLE);
  assign done     = w_done;
  assign stage    = r_stage;
  assign rd_en    = w_rd_en;
  assign rd_adr_a = w_rd_a;
  assign rd_adr_b = w_rd_b;
  assign tw_adr   = w_tw;

`ifdef FFT_BITREV_LOAD_EN
  // The delay line is empty during LOAD, so load writes and write-backs never collide.
  assign in_ready = w_in_ready;
  assign load_sel = w_load_sel;
  assign wr_en    = w_dly_en | w_load_wr;
  assign wr_adr_a = w_load_wr ? N_LOG2'(bitrev(FFT_MAX_W'(r_ld_cnt), N_LOG2)) : w_dly_a;
  assign wr_adr_b = w_dly_b;
`else
  assign wr_en    = w_dly_en;
  assign wr_adr_a = w_dly_a;
  assign wr_adr_b = w_dly_b;
`endif

endmodule
